// File: rtl/qspi_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : qspi_cmd_arbiter
//  Purpose  : Two-requester command arbiter/sequencer for the QSPI controller.
//             Arbitrates m0 (CSR) and m1 (XIP), issues a one-cycle start,
//             waits for completion and inserts a guard gap after QPI
//             enter/exit instructions.
//  Options  : QSPI_ARB_RR_EN - round-robin tie-break (default: m0 priority)
//  Revision : 1.0 - initial release
// ============================================================================
module qspi_cmd_arbiter #(
    parameter int         ADDR_W     = 24,
    parameter int         LEN_W      = 8,
    parameter logic [7:0] QPIEN_CODE = 8'h35,
    parameter logic [7:0] QPIDI_CODE = 8'hF5,
    parameter int         GUARD_CYC  = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic [7:0]        m0_inst,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [LEN_W-1:0]  m0_len,
    output logic              m0_done,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic [7:0]        m1_inst,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [LEN_W-1:0]  m1_len,
    output logic              m1_done,
    output logic              io_start_signal,
    output logic [7:0]        io_inst,
    output logic [ADDR_W-1:0] io_addr,
    output logic [LEN_W-1:0]  io_len,
    input  logic              io_next_req,
    output logic              grant_id,
    output logic              busy
);

    localparam int c_CNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_GUARD_LOAD = c_CNT_W'(GUARD_CYC - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_GUARD = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_guard_cnt;
    logic               r_mode_sw;
    logic               r_start;
    logic [7:0]         r_inst;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic               r_grant;
    logic               r_busy;
    logic               r_m0_done;
    logic               r_m1_done;
    logic               w_m0_win;
    logic               w_m1_win;
    logic               w_accept;
    logic               w_done_now;
    logic [7:0]         w_sel_inst;

`ifdef QSPI_ARB_RR_EN
    logic               r_last_grant;
`endif

    // Arbitration: pick the winner among the asserted valids
    always_comb begin
        w_m0_win = 1'b0;
        w_m1_win = 1'b0;
`ifdef QSPI_ARB_RR_EN
        if (m0_valid && m1_valid) begin
            w_m0_win = r_last_grant;
            w_m1_win = ~r_last_grant;
        end else begin
            w_m0_win = m0_valid;
            w_m1_win = m1_valid;
        end
`else
        w_m0_win = m0_valid;
        w_m1_win = m1_valid & ~m0_valid;
`endif
    end

    // Output decode: readies are the only combinational outputs
    always_comb begin
        m0_ready   = (r_state == c_IDLE) && !rst && w_m0_win;
        m1_ready   = (r_state == c_IDLE) && !rst && w_m1_win;
        w_accept   = (m0_valid && m0_ready) || (m1_valid && m1_ready);
        w_sel_inst = m1_ready ? m1_inst : m0_inst;
        w_done_now = (r_state == c_WAIT) && io_next_req;
    end

    // Next-state logic for the command sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next_state = c_ISSUE;
            c_ISSUE: w_next_state = c_WAIT;
            c_WAIT:  if (io_next_req) w_next_state = r_mode_sw ? c_GUARD : c_IDLE;
            c_GUARD: if (r_guard_cnt == '0) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    // Registered outputs, command latch, guard counter and done pulses
    always_ff @(posedge clock) begin
        if (rst) begin
            r_start     <= 1'b0;
            r_inst      <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_grant     <= 1'b0;
            r_busy      <= 1'b0;
            r_mode_sw   <= 1'b0;
            r_guard_cnt <= '0;
            r_m0_done   <= 1'b0;
            r_m1_done   <= 1'b0;
`ifdef QSPI_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_start   <= (w_next_state == c_ISSUE);
            r_busy    <= (w_next_state != c_IDLE);
            r_m0_done <= w_done_now && !r_grant;
            r_m1_done <= w_done_now &&  r_grant;
            if (w_accept) begin
                r_inst    <= w_sel_inst;
                r_addr    <= m1_ready ? m1_addr : m0_addr;
                r_len     <= m1_ready ? m1_len  : m0_len;
                r_grant   <= m1_ready;
                r_mode_sw <= (w_sel_inst == QPIEN_CODE) || (w_sel_inst == QPIDI_CODE);
`ifdef QSPI_ARB_RR_EN
                r_last_grant <= m1_ready;
`endif
            end
            if (w_done_now) begin
                r_guard_cnt <= c_GUARD_LOAD;
            end else if ((r_state == c_GUARD) && (r_guard_cnt != '0)) begin
                r_guard_cnt <= r_guard_cnt - 1'b1;
            end
        end
    end

    assign io_start_signal = r_start;
    assign io_inst         = r_inst;
    assign io_addr         = r_addr;
    assign io_len          = r_len;
    assign grant_id        = r_grant;
    assign busy            = r_busy;
    assign m0_done         = r_m0_done;
    assign m1_done         = r_m1_done;

endmodule
`default_nettype wire

// File: tb/tb_qspi_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_qspi_cmd_arbiter
//  Purpose  : Directed vector bench for qspi_cmd_arbiter (either build of
//             QSPI_ARB_RR_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_cmd_arbiter;

    localparam int ADDR_W    = 24;
    localparam int LEN_W     = 8;
    localparam int GUARD_CYC = 4;
`ifdef QSPI_ARB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              rst;
    logic              m0_valid, m1_valid;
    logic              m0_ready, m1_ready;
    logic [7:0]        m0_inst, m1_inst;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [LEN_W-1:0]  m0_len, m1_len;
    logic              m0_done, m1_done;
    logic              io_start_signal;
    logic [7:0]        io_inst;
    logic [ADDR_W-1:0] io_addr;
    logic [LEN_W-1:0]  io_len;
    logic              io_next_req;
    logic              grant_id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    qspi_cmd_arbiter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .QPIEN_CODE(8'h35),
        .QPIDI_CODE(8'hF5), .GUARD_CYC(GUARD_CYC)
    ) dut (
        .clock(clock), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_inst(m0_inst),
        .m0_addr(m0_addr), .m0_len(m0_len), .m0_done(m0_done),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_inst(m1_inst),
        .m1_addr(m1_addr), .m1_len(m1_len), .m1_done(m1_done),
        .io_start_signal(io_start_signal), .io_inst(io_inst),
        .io_addr(io_addr), .io_len(io_len), .io_next_req(io_next_req),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              v0;
        logic              v1;
        logic [7:0]        i0;
        logic [ADDR_W-1:0] a0;
        logic [LEN_W-1:0]  l0;
        logic [7:0]        i1;
        logic [ADDR_W-1:0] a1;
        logic [LEN_W-1:0]  l1;
        int                lat;
        logic              gid;
        logic [7:0]        e_inst;
        logic [ADDR_W-1:0] e_addr;
        logic [LEN_W-1:0]  e_len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: m1 alone, four ties, m0 alone, m1 alone (last leaves last_grant=m1)
        vecs[0] = '{1'b0, 1'b1, 8'h00, 24'h0, 8'd0, 8'h0B, 24'h001000, 8'd32, 0,
                    1'b1, 8'h0B, 24'h001000, 8'd32};
        vecs[1] = '{1'b1, 1'b1, 8'h03, 24'h000100, 8'd4, 8'h0B, 24'hABCDEF, 8'd16, 1,
                    1'b0, 8'h03, 24'h000100, 8'd4};
        vecs[2] = '{1'b1, 1'b1, 8'h03, 24'h000100, 8'd4, 8'h0B, 24'hABCDEF, 8'd16, 0,
                    c_RR, c_RR ? 8'h0B : 8'h03, c_RR ? 24'hABCDEF : 24'h000100,
                    c_RR ? 8'd16 : 8'd4};
        vecs[3] = '{1'b1, 1'b1, 8'h03, 24'h000100, 8'd4, 8'h0B, 24'hABCDEF, 8'd16, 2,
                    1'b0, 8'h03, 24'h000100, 8'd4};
        vecs[4] = '{1'b1, 1'b1, 8'h03, 24'h000100, 8'd4, 8'h0B, 24'hABCDEF, 8'd16, 0,
                    c_RR, c_RR ? 8'h0B : 8'h03, c_RR ? 24'hABCDEF : 24'h000100,
                    c_RR ? 8'd16 : 8'd4};
        vecs[5] = '{1'b1, 1'b0, 8'h03, 24'h123456, 8'hFF, 8'h00, 24'h0, 8'd0, 3,
                    1'b0, 8'h03, 24'h123456, 8'hFF};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 24'h0, 8'd0, 8'h9F, 24'h000000, 8'd3, 0,
                    1'b1, 8'h9F, 24'h000000, 8'd3};

        // ---- reset with m0_valid held ----
        rst = 1'b1; io_next_req = 1'b0;
        m0_valid = 1'b1; m0_inst = 8'h03; m0_addr = 24'h000040; m0_len = 8'd8;
        m1_valid = 1'b0; m1_inst = 8'h00; m1_addr = '0; m1_len = '0;
        repeat (2) tick();
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(io_start_signal), 32'd0);
        chk("rst_io", {io_inst, io_addr}, 32'd0);
        chk("rst_len_gid_done", {io_len, grant_id, m0_done, m1_done}, 32'd0);
        rst = 1'b0; #1;
        chk("post_rst_m0_ready", 32'(m0_ready), 32'd1);
        tick();
        m0_valid = 1'b0;
        chk("post_rst_start", 32'(io_start_signal), 32'd1);
        chk("post_rst_inst", 32'(io_inst), 32'h03);
        chk("post_rst_gid", 32'(grant_id), 32'd0);
        tick();
        chk("post_rst_wait", {io_start_signal, busy}, 32'b01);
        io_next_req = 1'b1; tick(); io_next_req = 1'b0;
        chk("post_rst_done", {m0_done, m1_done}, 32'b10);

        // ---- table-driven transactions ----
        for (int k = 0; k < 7; k++) begin
            m0_valid = vecs[k].v0; m0_inst = vecs[k].i0; m0_addr = vecs[k].a0; m0_len = vecs[k].l0;
            m1_valid = vecs[k].v1; m1_inst = vecs[k].i1; m1_addr = vecs[k].a1; m1_len = vecs[k].l1;
            #1;
            chk($sformatf("v%0d_m0_ready", k), 32'(m0_ready), 32'(!vecs[k].gid));
            chk($sformatf("v%0d_m1_ready", k), 32'(m1_ready), 32'(vecs[k].gid));
            tick();
            m0_valid = 1'b0; m1_valid = 1'b0;
            chk($sformatf("v%0d_start", k), 32'(io_start_signal), 32'd1);
            chk($sformatf("v%0d_inst", k), 32'(io_inst), 32'(vecs[k].e_inst));
            chk($sformatf("v%0d_addr", k), 32'(io_addr), 32'(vecs[k].e_addr));
            chk($sformatf("v%0d_len", k), 32'(io_len), 32'(vecs[k].e_len));
            chk($sformatf("v%0d_gid", k), 32'(grant_id), 32'(vecs[k].gid));
            chk($sformatf("v%0d_busy_nodone", k), {busy, m0_done, m1_done}, 32'b100);
            tick();
            chk($sformatf("v%0d_start_one_cycle", k), 32'(io_start_signal), 32'd0);
            repeat (vecs[k].lat) tick();
            chk($sformatf("v%0d_wait_busy", k), {busy, m0_done, m1_done}, 32'b100);
            io_next_req = 1'b1; tick(); io_next_req = 1'b0;
            chk($sformatf("v%0d_done", k), {m0_done, m1_done},
                vecs[k].gid ? 32'b01 : 32'b10);
            chk($sformatf("v%0d_idle", k), 32'(busy), 32'd0);
            chk($sformatf("v%0d_io_hold", k), 32'(io_inst), 32'(vecs[k].e_inst));
        end

        // ---- io_next_req in IDLE is ignored ----
        io_next_req = 1'b1; tick(); io_next_req = 1'b0;
        chk("idle_nreq_done", {m0_done, m1_done}, 32'd0);
        chk("idle_nreq_busy", 32'(busy), 32'd0);

        // ---- mode-switch guard: m0 QPI enter with m1 waiting ----
        m0_valid = 1'b1; m0_inst = 8'h35; m0_addr = 24'h0; m0_len = 8'd0;
        m1_valid = 1'b1; m1_inst = 8'h03; m1_addr = 24'h000200; m1_len = 8'd1;
        #1;
        chk("g_m0_ready", {m0_ready, m1_ready}, 32'b10);
        tick();
        m0_valid = 1'b0;
        chk("g_start", 32'(io_start_signal), 32'd1);
        chk("g_inst", 32'(io_inst), 32'h35);
        chk("g_issue_m1_ready", 32'(m1_ready), 32'd0);
        io_next_req = 1'b1; tick(); io_next_req = 1'b0;   // pulse during ISSUE
        chk("g_issue_nreq_ignored", {busy, io_start_signal, m0_done, m1_done}, 32'b1000);
        io_next_req = 1'b1; tick(); io_next_req = 1'b0;   // completion in WAIT
        chk("g_done", {m0_done, m1_done}, 32'b10);
        chk("g_guard1_m1_ready", 32'(m1_ready), 32'd0);
        for (int g = 1; g < GUARD_CYC; g++) begin
            if (g == 1) io_next_req = 1'b1;               // pulse during GUARD
            tick();
            io_next_req = 1'b0;
            chk($sformatf("g_guard%0d_m1_ready", g + 1), 32'(m1_ready), 32'd0);
            chk($sformatf("g_guard%0d_busy_nodone", g + 1), {busy, m0_done, m1_done}, 32'b100);
        end
        tick();
        chk("g_after_m1_ready", 32'(m1_ready), 32'd1);
        chk("g_after_busy", 32'(busy), 32'd0);
        tick();
        m1_valid = 1'b0;
        chk("g_m1_start", {io_start_signal, grant_id}, 32'b11);
        chk("g_m1_inst", 32'(io_inst), 32'h03);
        tick();
        io_next_req = 1'b1; tick(); io_next_req = 1'b0;
        chk("g_m1_done", {m0_done, m1_done, busy}, 32'b010);
        m0_valid = 1'b1; m0_inst = 8'h03; m0_addr = 24'h000300; m0_len = 8'd2;
        #1;
        chk("nomode_no_guard_ready", 32'(m0_ready), 32'd1);

        // ---- reset mid-WAIT abandons the command ----
        tick();
        m0_valid = 1'b0; m1_valid = 1'b1;
        tick();
        chk("rw_in_wait", {busy, io_start_signal}, 32'b10);
        rst = 1'b1; #1;
        chk("rw_rst_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        chk("rw_outputs", {busy, io_start_signal, grant_id, m0_done, m1_done}, 32'd0);
        chk("rw_io", {io_inst, io_addr}, 32'd0);
        rst = 1'b0; m1_valid = 1'b0;
        io_next_req = 1'b1; tick(); io_next_req = 1'b0;
        chk("rw_nreq_ignored", {busy, m0_done, m1_done}, 32'd0);
        tick();
        chk("rw_still_idle", {busy, m0_done, m1_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
